// File: rtl/packet_sequencer.sv
// packet_sequencer: runs one packet_constructor per L0 event, from stamping through
// cluster arbitration, the no-0/1 flag and the readout handshake.
module packet_sequencer #(
  parameter int CLSTR_NUM = 4,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        L0_REQ,
  input  logic [15:0] L0_BC_ID,
  output logic        L0_ACK,
  input  logic        SEG0_VLD,
  input  logic        SEG1_VLD,
  input  logic [6:0]  SEG0_DATA,
  input  logic [6:0]  SEG1_DATA,
  input  logic        SEG0_DONE,
  input  logic        SEG1_DONE,
  output logic        SEG0_RDY,
  output logic        SEG1_RDY,
  input  logic        NO01_FLAG,
  output logic        PCKT_RST_O,
  output logic [15:0] L0_BC_ID_O,
  output logic        CLSTR_RDY_O,
  output logic        SEG_ID_O,
  output logic [6:0]  DATA_O,
  output logic        NO_0_1_O,
  output logic        PCKT_VLD,
  input  logic        PCKT_ACK,
  output logic [7:0]  DROP_CNT,
  output logic        TIMEOUT_ERR
);
  localparam int CW = $clog2(CLSTR_NUM + 2);
  typedef enum logic [2:0] {IDLE, START, COLLECT, FLAG, WAIT_ACK} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic no01_q, no01_d;
  logic l0_ack_q, l0_ack_d, pckt_rst_q, pckt_rst_d;
  logic [15:0] bcid_q, bcid_d;
  logic clstr_rdy_q, clstr_rdy_d, seg_id_q, seg_id_d;
  logic [6:0] data_q, data_d;
  logic no_0_1_q, no_0_1_d, pckt_vld_q, pckt_vld_d;
  logic [7:0] drop_q, drop_d;
  logic to_err_q, to_err_d;
  logic collect, to_hit, en, g0, g1, xfer, keep, done_all;
  // The timeout cycle itself withholds grants, so collection always ends in that cycle.
  assign collect  = state_q == COLLECT;
  assign to_hit   = collect && to_q == TO_W'(TIMEOUT - 1);
  assign en       = collect && !to_hit;
  assign g0       = en && SEG0_VLD && (!SEG1_VLD || !ptr_q);
  assign g1       = en && SEG1_VLD && (!SEG0_VLD || ptr_q);
  assign xfer     = g0 || g1;
  assign keep     = cnt_q <= CW'(CLSTR_NUM);
  assign done_all = SEG0_DONE && !SEG0_VLD && SEG1_DONE && !SEG1_VLD;
  assign SEG0_RDY = g0;
  assign SEG1_RDY = g1;
  always_comb begin
    state_d     = state_q;
    ptr_d       = (xfer && SEG0_VLD && SEG1_VLD) ? !ptr_q : ptr_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    no01_d      = no01_q;
    bcid_d      = bcid_q;
    drop_d      = drop_q;
    to_err_d    = to_err_q || to_hit;
    clstr_rdy_d = xfer && keep;
    seg_id_d    = (xfer && keep) ? g1 : seg_id_q;
    data_d      = (xfer && keep) ? (g1 ? SEG1_DATA : SEG0_DATA) : data_q;
    unique case (state_q)
      IDLE: if (L0_REQ) begin
        bcid_d  = L0_BC_ID;
        drop_d  = 8'd0;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        no01_d  = 1'b0;
        to_d    = '0;
        state_d = COLLECT;
      end
      COLLECT: begin
        to_d   = to_q + 1'b1;
        no01_d = no01_q || NO01_FLAG;
        if (xfer && keep) cnt_d = cnt_q + 1'b1;
        if (xfer && !keep) drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        if (!xfer && (done_all || to_hit)) state_d = FLAG;
      end
      FLAG:     state_d = WAIT_ACK;
      WAIT_ACK: state_d = PCKT_ACK ? IDLE : WAIT_ACK;
      default:  state_d = IDLE;
    endcase
    l0_ack_d   = state_d == START;
    pckt_rst_d = state_d == START;
    no_0_1_d   = state_d == FLAG && no01_d;
    pckt_vld_d = state_d == WAIT_ACK;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      to_q        <= '0;
      no01_q      <= 1'b0;
      l0_ack_q    <= 1'b0;
      pckt_rst_q  <= 1'b0;
      bcid_q      <= 16'd0;
      clstr_rdy_q <= 1'b0;
      seg_id_q    <= 1'b0;
      data_q      <= 7'd0;
      no_0_1_q    <= 1'b0;
      pckt_vld_q  <= 1'b0;
      drop_q      <= 8'd0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      no01_q      <= no01_d;
      l0_ack_q    <= l0_ack_d;
      pckt_rst_q  <= pckt_rst_d;
      bcid_q      <= bcid_d;
      clstr_rdy_q <= clstr_rdy_d;
      seg_id_q    <= seg_id_d;
      data_q      <= data_d;
      no_0_1_q    <= no_0_1_d;
      pckt_vld_q  <= pckt_vld_d;
      drop_q      <= drop_d;
      to_err_q    <= to_err_d;
    end
  end
  assign L0_ACK      = l0_ack_q;
  assign PCKT_RST_O  = pckt_rst_q;
  assign L0_BC_ID_O  = bcid_q;
  assign CLSTR_RDY_O = clstr_rdy_q;
  assign SEG_ID_O    = seg_id_q;
  assign DATA_O      = data_q;
  assign NO_0_1_O    = no_0_1_q;
  assign PCKT_VLD    = pckt_vld_q;
  assign DROP_CNT    = drop_q;
  assign TIMEOUT_ERR = to_err_q;
endmodule

// File: tb/tb_packet_sequencer.sv
// tb_packet_sequencer: randomized event traffic checked against a cycle-level model of
// the event flow, plus the directed scenarios for empty, overflow, no-0/1, timeout and abort.
module tb_packet_sequencer;
  localparam int CN = 4;
  localparam int TO = 16;
  logic CLK = 0, RST = 0, L0_REQ = 0, L0_ACK;
  logic [15:0] L0_BC_ID = 0, L0_BC_ID_O;
  logic SEG0_VLD = 0, SEG1_VLD = 0, SEG0_DONE = 0, SEG1_DONE = 0, SEG0_RDY, SEG1_RDY;
  logic [6:0] SEG0_DATA = 0, SEG1_DATA = 0, DATA_O;
  logic NO01_FLAG = 0, PCKT_RST_O, CLSTR_RDY_O, SEG_ID_O, NO_0_1_O, PCKT_VLD, PCKT_ACK = 0;
  logic [7:0] DROP_CNT;
  logic TIMEOUT_ERR;
  int checks = 0, errors = 0;
  logic [6:0] q0[$], q1[$];
  logic [7:0] obs[$];
  bit mptr = 0, merr = 0, saw_no01;
  int vld_lat, last_cc;
  always #5 CLK = ~CLK;
  packet_sequencer #(.CLSTR_NUM(CN), .TIMEOUT(TO), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST), .L0_REQ(L0_REQ), .L0_BC_ID(L0_BC_ID), .L0_ACK(L0_ACK),
    .SEG0_VLD(SEG0_VLD), .SEG1_VLD(SEG1_VLD), .SEG0_DATA(SEG0_DATA), .SEG1_DATA(SEG1_DATA),
    .SEG0_DONE(SEG0_DONE), .SEG1_DONE(SEG1_DONE), .SEG0_RDY(SEG0_RDY), .SEG1_RDY(SEG1_RDY),
    .NO01_FLAG(NO01_FLAG), .PCKT_RST_O(PCKT_RST_O), .L0_BC_ID_O(L0_BC_ID_O),
    .CLSTR_RDY_O(CLSTR_RDY_O), .SEG_ID_O(SEG_ID_O), .DATA_O(DATA_O), .NO_0_1_O(NO_0_1_O),
    .PCKT_VLD(PCKT_VLD), .PCKT_ACK(PCKT_ACK), .DROP_CNT(DROP_CNT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({L0_ACK, PCKT_RST_O, L0_BC_ID_O, CLSTR_RDY_O, SEG_ID_O, DATA_O, NO_0_1_O,
                PCKT_VLD, DROP_CNT, TIMEOUT_ERR, SEG0_RDY, SEG1_RDY});
  endfunction
  // Called at posedge+1 with the DUT idle; returns at posedge+1.
  task automatic run_event(input logic [15:0] bcid, input bit dense, input int no01_mode,
                           input bit hold1, input int abort);
    int cyc = 0, phase = 0, cc = 0, nx = 0, wait_n;
    bit pend = 0, lat = 0, fin = 0, r0 = 0, r1 = 0, e0, e1;
    logic [7:0] pval = 0;
    obs.delete();
    saw_no01 = 0;
    vld_lat = -1;
    wait_n = $urandom_range(3);
    L0_REQ = 1;
    L0_BC_ID = bcid;
    while (!fin && cyc < 300) begin
      if (r0) void'(q0.pop_front());
      if (r1) void'(q1.pop_front());
      SEG0_VLD = phase < 2 && q0.size() > 0 && ((SEG0_VLD && !r0) || dense || $urandom_range(3) != 0);
      SEG1_VLD = phase < 2 && q1.size() > 0 && ((SEG1_VLD && !r1) || dense || $urandom_range(3) != 0);
      SEG0_DATA = q0.size() > 0 ? q0[0] : 7'h0;
      SEG1_DATA = q1.size() > 0 ? q1[0] : 7'h0;
      SEG0_DONE = q0.size() == 0 || (q0.size() == 1 && SEG0_VLD);
      SEG1_DONE = !hold1 && (q1.size() == 0 || (q1.size() == 1 && SEG1_VLD));
      NO01_FLAG = phase == 1 && (no01_mode == 1 ? $urandom_range(7) == 0 :
                  no01_mode == 2 ? (q0.size() + q1.size() == 1 && (SEG0_VLD || SEG1_VLD)) : 1'b0);
      PCKT_ACK = phase < 3 ? $urandom_range(5) == 0 : (phase == 3 && wait_n <= 0);
      if (cyc >= 2) L0_REQ = 0;
      @(negedge CLK);
      cyc++;
      r0 = SEG0_VLD && SEG0_RDY;
      r1 = SEG1_VLD && SEG1_RDY;
      chk("strobe", 64'(CLSTR_RDY_O), 64'(pend));
      if (pend) chk("strobe_word", 64'({SEG_ID_O, DATA_O}), 64'(pval));
      if (CLSTR_RDY_O) obs.push_back({SEG_ID_O, DATA_O});
      chk("no01_strobe_overlap", 64'(CLSTR_RDY_O & NO_0_1_O), 0);
      pend = 0;
      e0 = 0;
      e1 = 0;
      if (phase == 1) begin
        cc++;
        e0 = cc != TO && SEG0_VLD && (!SEG1_VLD || !mptr);
        e1 = cc != TO && SEG1_VLD && (!SEG0_VLD || mptr);
      end
      chk("grant", 64'({SEG1_RDY, SEG0_RDY}), 64'({e1, e0}));
      if (phase != 2) chk("no01_idle", 64'(NO_0_1_O), 0);
      if (phase != 0) chk("l0_ack_idle", 64'(L0_ACK), 0);
      case (phase)
        0: begin
          chk("l0_ack", 64'(L0_ACK), 64'(cyc == 2));
          chk("pckt_rst", 64'(PCKT_RST_O), 64'(cyc == 2));
          if (cyc == 2) begin
            chk("bcid", 64'(L0_BC_ID_O), 64'(bcid));
            phase = 1;
          end
        end
        1: begin
          if (e0 || e1) begin
            if (nx <= CN) begin
              pend = 1;
              pval = e1 ? {1'b1, SEG1_DATA} : {1'b0, SEG0_DATA};
            end
            nx++;
            if (SEG0_VLD && SEG1_VLD) mptr = !mptr;
          end
          lat |= NO01_FLAG;
          if (!(e0 || e1) && (cc == TO ||
              (SEG0_DONE && !SEG0_VLD && SEG1_DONE && !SEG1_VLD))) begin
            phase = 2;
            last_cc = cc;
            if (cc == TO) merr = 1;
          end
        end
        2: begin
          chk("no01_out", 64'(NO_0_1_O), 64'(lat));
          chk("vld_in_flag", 64'(PCKT_VLD), 0);
          chk("timeout_err", 64'(TIMEOUT_ERR), 64'(merr));
          saw_no01 = NO_0_1_O;
          q0.delete();
          q1.delete();
          r0 = 0;
          r1 = 0;
          phase = 3;
        end
        3: begin
          chk("pckt_vld", 64'(PCKT_VLD), 1);
          if (vld_lat < 0) vld_lat = cyc - 2;
          chk("drop_cnt", 64'(DROP_CNT), 64'(nx > CN + 1 ? ((nx - CN - 1) > 255 ? 255 : nx - CN - 1) : 0));
          chk("timeout_err_wait", 64'(TIMEOUT_ERR), 64'(merr));
          if (PCKT_ACK) phase = 4;
          else wait_n--;
        end
        default: begin
          chk("vld_drop", 64'(PCKT_VLD), 0);
          fin = 1;
        end
      endcase
      if (abort > 0 && phase == 1 && obs.size() == abort) begin
        #1 RST = 0;
        #1 chk("reset_outs_mid", outs(), 0);
        mptr = 0;
        merr = 0;
        {L0_REQ, SEG0_VLD, SEG1_VLD, SEG0_DONE, SEG1_DONE, NO01_FLAG, PCKT_ACK} = '0;
        q0.delete();
        q1.delete();
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1;
        for (int i = 0; i < 6; i++) begin
          @(negedge CLK);
          chk("no_vld_after_abort", 64'(PCKT_VLD), 0);
        end
        @(posedge CLK);
        #1;
        return;
      end
      @(posedge CLK);
      #1;
    end
    chk("event_done", 64'(fin), 1);
    PCKT_ACK = 0;
    {SEG0_VLD, SEG1_VLD, NO01_FLAG} = '0;
  endtask
  initial begin
    logic [6:0] w[$];
    repeat (2) @(posedge CLK);
    #1 chk("reset_outs", outs(), 0);
    RST = 1;
    @(posedge CLK);
    #1;
    run_event(16'hA5C3, 1, 0, 0, 0);
    chk("t1_vld_latency", 64'(vld_lat), 3);
    chk("t1_no_strobes", 64'(obs.size()), 0);
    chk("t1_no01", 64'(saw_no01), 0);
    q0 = '{7'h11, 7'h12};
    q1 = '{7'h21, 7'h22};
    run_event(16'h1234, 1, 0, 0, 0);
    chk("t2_count", 64'(obs.size()), 4);
    if (obs.size() == 4) chk("t2_slots", 64'({obs[0], obs[1], obs[2], obs[3]}), 64'(32'h11A112A2));
    for (int i = 0; i < 10; i++) w.push_back(7'($urandom));
    q0 = w;
    run_event(16'($urandom), 1, 0, 0, 0);
    chk("t3_strobes", 64'(obs.size()), 5);
    chk("t3_drop", 64'(DROP_CNT), 5);
    for (int i = 0; i < 5 && i < obs.size(); i++) chk("t3_slot", 64'(obs[i]), 64'({1'b0, w[i]}));
    q0 = '{7'h05, 7'h06};
    q1 = '{7'h07};
    run_event(16'($urandom), 1, 2, 0, 0);
    chk("t4_no01", 64'(saw_no01), 1);
    chk("t4_not_empty", 64'(obs.size() > 0), 1);
    chk("t5_err_before", 64'(TIMEOUT_ERR), 0);
    run_event(16'($urandom), 0, 0, 1, 0);
    chk("t5_cycles", 64'(last_cc), 16);
    chk("t5_err", 64'(TIMEOUT_ERR), 1);
    for (int e = 0; e < 25; e++) begin
      for (int i = $urandom_range(7); i > 0; i--) q0.push_back(7'($urandom));
      for (int i = $urandom_range(7); i > 0; i--) q1.push_back(7'($urandom));
      run_event(16'($urandom), $urandom_range(1), $urandom_range(2), 0, 0);
    end
    for (int i = 0; i < 6; i++) q0.push_back(7'($urandom));
    run_event(16'($urandom), 1, 0, 0, 2);
    q1 = '{7'h33};
    run_event(16'hBEEF, 1, 0, 0, 0);
    chk("t6_drop_clean", 64'(DROP_CNT), 0);
    chk("t6_err_clean", 64'(TIMEOUT_ERR), 0);
    chk("t6_strobe", 64'(obs.size()), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
